// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_serie.sv
// Unsigned shift-add multiplier: one partial product per cycle for WIDTH cycles.
// prod is the accumulator including the current step, so it is final while done=1.
module alu_mul_serie #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               run_p1;
  logic [CW-1:0]      cnt_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0]   mplr_p1;
  logic [2*WIDTH-1:0] acc_p0;

  // stage p0: add the current partial product
  assign acc_p0 = acc_p1 + (mplr_p1[0] ? mcand_p1 : '0);
  assign done   = run_p1 && (cnt_p1 == CW'(WIDTH - 1));
  assign prod   = acc_p0;

  // stage p1: iteration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_p1   <= 1'b0;
      cnt_p1   <= '0;
      acc_p1   <= '0;
      mcand_p1 <= '0;
      mplr_p1  <= '0;
    end else if (start) begin
      run_p1   <= 1'b1;
      cnt_p1   <= '0;
      acc_p1   <= '0;
      mcand_p1 <= {{WIDTH{1'b0}}, a};
      mplr_p1  <= b;
    end else if (run_p1) begin
      acc_p1   <= acc_p0;
      mcand_p1 <= mcand_p1 << 1;
      mplr_p1  <= mplr_p1 >> 1;
      cnt_p1   <= cnt_p1 + 1'b1;
      if (done) run_p1 <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_registrada.sv
// Registered ALU: single-cycle logic/arith/shift ops, multi-cycle serial MUL,
// optional accumulator chaining through the result register.
module alu_registrada
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  input  logic             acc_mode,
  input  logic             disp_sel,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             valid,
  output logic             busy,
  output logic [WIDTH-1:0] uo
);

  state_t               state, state_nx;
  logic [WIDTH-1:0]     opa_p0, res_p0;
  logic                 c_p0, v_p0;
  logic [WIDTH:0]       sum_p0, shl_p0, shr_p0;
  logic                 sh_big_p0;
  logic                 alu_go, mul_go, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  function automatic logic [3:0] mk_flags(input logic c, input logic v,
                                          input logic [WIDTH-1:0] r);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    return f;
  endfunction

  assign opa_p0    = acc_mode ? result : a;
  assign alu_go    = (state == IDLE) && start && (op != OP_MUL);
  assign mul_go    = (state == IDLE) && start && (op == OP_MUL);
  assign sh_big_p0 = ({{(32-SHW){1'b0}}, shamt} >= 32'(WIDTH));

  // stage p0: single-cycle datapath
  always_comb begin
    res_p0 = '0;
    c_p0   = 1'b0;
    v_p0   = 1'b0;
    sum_p0 = '0;
    shl_p0 = '0;
    shr_p0 = '0;
    case (op)
      OP_ADD: begin
        sum_p0 = {1'b0, opa_p0} + {1'b0, b};
        res_p0 = sum_p0[WIDTH-1:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = (opa_p0[WIDTH-1] == b[WIDTH-1]) && (res_p0[WIDTH-1] != opa_p0[WIDTH-1]);
      end
      OP_SUB: begin
        sum_p0 = {1'b0, opa_p0} - {1'b0, b};
        res_p0 = sum_p0[WIDTH-1:0];
        c_p0   = ~sum_p0[WIDTH];
        v_p0   = (opa_p0[WIDTH-1] != b[WIDTH-1]) && (res_p0[WIDTH-1] != opa_p0[WIDTH-1]);
      end
      OP_AND: res_p0 = opa_p0 & b;
      OP_OR:  res_p0 = opa_p0 | b;
      OP_XOR: res_p0 = opa_p0 ^ b;
      // the extra bit beside the operand catches the last bit shifted out
      OP_SHL: if (!sh_big_p0) begin
        shl_p0 = {1'b0, opa_p0} << shamt;
        res_p0 = shl_p0[WIDTH-1:0];
        c_p0   = shl_p0[WIDTH];
      end
      OP_SHR: if (!sh_big_p0) begin
        shr_p0 = {opa_p0, 1'b0} >> shamt;
        res_p0 = shr_p0[WIDTH:1];
        c_p0   = shr_p0[0];
      end
      default: ;
    endcase
  end

  alu_mul_serie #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_go),
    .a     (opa_p0),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (mul_go) state_nx = MUL;
      MUL: begin
        busy = 1'b1;
        if (mul_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // stage p1: architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
      valid  <= 1'b0;
    end else begin
      state <= state_nx;
      valid <= 1'b0;
      if (alu_go) begin
        result <= res_p0;
        flags  <= mk_flags(c_p0, v_p0, res_p0);
        valid  <= 1'b1;
      end else if (state == MUL && mul_done) begin
        result <= mul_prod[WIDTH-1:0];
        flags  <= mk_flags(|mul_prod[2*WIDTH-1:WIDTH], 1'b0, mul_prod[WIDTH-1:0]);
        valid  <= 1'b1;
      end
    end
  end

  always_comb begin
    uo = '0;
    if (disp_sel) uo[3:0] = flags;
    else          uo = result;
  end

endmodule

// File: tb/tb_alu_registrada.sv
// Directed and randomized checks of alu_registrada (WIDTH=8, 4-bit shamt) with a result scoreboard.
module tb_alu_registrada;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MULT = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic [3:0] shamt = '0;
  logic       start = 1'b0, acc_mode = 1'b0, disp_sel = 1'b0;
  logic [7:0] result, uo;
  logic [3:0] flags;
  logic       valid, busy;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb[$];
  logic [7:0]  exp_acc = '0;

  alu_registrada #(.WIDTH(8), .SHW(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .shamt(shamt), .start(start),
    .acc_mode(acc_mode), .disp_sel(disp_sel), .result(result), .flags(flags),
    .valid(valid), .busy(busy), .uo(uo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // independent reference: integer arithmetic and bit-by-bit shifting
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x,
                                        input logic [7:0] y, input logic [3:0] sh);
    int ux, uy, sx, sy, r, s;
    logic c, v;
    logic [7:0] res;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    c = 1'b0; v = 1'b0; res = '0; r = 0; s = 0;
    case (o)
      ADD:  begin r = ux + uy; res = r[7:0]; c = (r > 255); s = sx + sy; v = (s > 127) || (s < -128); end
      SUB:  begin r = ux - uy; res = r[7:0]; c = (ux >= uy); s = sx - sy; v = (s > 127) || (s < -128); end
      AND_: res = x & y;
      OR_:  res = x | y;
      XOR_: res = x ^ y;
      SHL:  begin res = x; for (int i = 0; i < sh; i++) begin c = res[7]; res = {res[6:0], 1'b0}; end
                  if (sh >= 8) c = 1'b0; end
      SHR:  begin res = x; for (int i = 0; i < sh; i++) begin c = res[0]; res = {1'b0, res[7:1]}; end
                  if (sh >= 8) c = 1'b0; end
      default: begin r = ux * uy; res = r[7:0]; c = (r > 255); end
    endcase
    return {res, c, v, res[7], (res == 8'h00)};
  endfunction

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      check("sb_nonempty_on_valid", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [11:0] e;
        e = sb.pop_front();
        check("result", result, e[11:4]);
        check("flags", flags, e[3:0]);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [3:0] sh, input logic acc, input logic [7:0] er,
                       input logic [3:0] ef, input int elat, input bit poke);
    int lat, busy_cnt;
    sb.push_back({er, ef});
    exp_acc = er;
    op = o; a = ia; b = ib; shamt = sh; acc_mode = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy_cnt = 0;
    if (elat == 1) check("busy_alu", busy, 0);
    while (valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke && lat == 3) begin
        start = 1'b1; op = ADD; a = 8'h01; b = 8'h01; acc_mode = 1'b0;
      end else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, elat);
    if (elat > 1) check("busy_cycles", busy_cnt, elat - 1);
    @(posedge clk); #1;
    check("valid_pulse", valid, 0);
  endtask

  task automatic issue_rand(input logic [2:0] o);
    logic [7:0] x, y;
    logic [3:0] sh;
    logic acc;
    logic [11:0] e;
    x = 8'($urandom); y = 8'($urandom); sh = 4'($urandom_range(0, 10));
    acc = 1'($urandom);
    e = model(o, acc ? exp_acc : x, y, sh);
    issue(o, x, y, sh, acc, e[11:4], e[3:0], (o == MULT) ? 9 : 1, 1'b0);
  endtask

  initial begin
    #1;
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_uo", uo, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    issue(ADD, 8'h7F, 8'h01, 0, 0, 8'h80, 4'b0110, 1, 0);
    issue(ADD, 8'hFF, 8'h01, 0, 0, 8'h00, 4'b1001, 1, 0);
    issue(SUB, 8'h05, 8'h05, 0, 0, 8'h00, 4'b1001, 1, 0);
    disp_sel = 1'b1; #1;
    check("uo_flags", uo, 8'h09);
    disp_sel = 1'b0;
    issue(SUB, 8'h03, 8'h05, 0, 0, 8'hFE, 4'b0010, 1, 0);
    issue(SUB, 8'h80, 8'h01, 0, 0, 8'h7F, 4'b1100, 1, 0);
    issue(AND_, 8'hF0, 8'h3C, 0, 0, 8'h30, 4'b0000, 1, 0);
    issue(OR_, 8'h0F, 8'hF0, 0, 0, 8'hFF, 4'b0010, 1, 0);
    issue(XOR_, 8'hAA, 8'hAA, 0, 0, 8'h00, 4'b0001, 1, 0);
    issue(SHL, 8'h81, 8'h00, 1, 0, 8'h02, 4'b1000, 1, 0);
    issue(SHR, 8'h81, 8'h00, 0, 0, 8'h81, 4'b0010, 1, 0);
    issue(SHR, 8'h81, 8'h00, 1, 0, 8'h40, 4'b1000, 1, 0);
    issue(SHR, 8'h81, 8'h00, 9, 0, 8'h00, 4'b0001, 1, 0);
    issue(SHL, 8'h81, 8'h00, 8, 0, 8'h00, 4'b0001, 1, 0);
    issue(MULT, 8'h10, 8'h20, 0, 0, 8'h00, 4'b1001, 9, 1);
    issue(MULT, 8'h0F, 8'h0F, 0, 0, 8'hE1, 4'b0010, 9, 0);
    issue(MULT, 8'hFF, 8'hFF, 0, 0, 8'h01, 4'b1000, 9, 0);

    issue(ADD, 8'h03, 8'h04, 0, 0, 8'h07, 4'b0000, 1, 0);
    issue(ADD, 8'hEE, 8'h05, 0, 1, 8'h0C, 4'b0000, 1, 0);
    disp_sel = 1'b1; #1;
    check("uo_disp1", uo, 8'h00);
    disp_sel = 1'b0; #1;
    check("uo_disp0", uo, 8'h0C);

    a = 8'h55; b = 8'h66; op = SUB;
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", result, 8'h0C);
    check("hold_flags", flags, 4'b0000);

    for (int i = 0; i < 12; i++) issue_rand(3'($urandom_range(0, 6)));
    issue_rand(MULT);
    issue_rand(MULT);

    issue(ADD, 8'h40, 8'h03, 0, 0, 8'h43, 4'b0000, 1, 0);
    op = MULT; a = 8'h0F; b = 8'h0F; acc_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    rst = 1'b1; #1;
    exp_acc = '0;
    check("rst_mid_result", result, 0);
    check("rst_mid_flags", flags, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", valid, 0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_hold_valid", valid, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    issue(ADD, 8'h11, 8'h22, 0, 0, 8'h33, 4'b0000, 1, 0);

    repeat (12) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_registrada.md
ALU_REGISTRADA -- requirements
Module: alu_registrada

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 SHALL have port shamt  input  SHW  shift amount for SHL/SHR.
REQ-009 SHALL have port start  input  1  one-cycle request, sampled with a, b, op, shamt, acc_mode.
REQ-010 SHALL have port acc_mode  input  1  when 1, operand A is the internal result register instead of a.
REQ-011 SHALL have port disp_sel  input  1  display select for uo.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port flags  output  4  registered {Carry, Overflow, Negative, Zero}.
REQ-014 SHALL have port valid  output  1  one-cycle pulse, result/flags updated.
REQ-015 SHALL have port busy  output  1  high while MUL in progress.
REQ-016 SHALL have port uo  output  WIDTH  disp_sel=0: result; disp_sel=1: {zeros, flags}.

Function
REQ-017 SHALL use FSM states IDLE and MUL; start accepted only in IDLE, ignored while busy=1.
REQ-018 For ops 000-110, start in IDLE SHALL update result/flags at the next rising edge with valid=1 for exactly that cycle (latency 1); state stays IDLE.
REQ-019 For MUL, start in IDLE SHALL latch operands, enter MUL, hold busy=1 for exactly WIDTH cycles of shift-add, then return to IDLE updating result/flags with valid=1 (latency WIDTH+1 edges from start).
REQ-020 ADD: result=(A+B) mod 2^WIDTH; C=carry-out; V=signed overflow.
REQ-021 SUB: result=(A-B) mod 2^WIDTH; C=1 when A>=B unsigned (no borrow); V=signed overflow.
REQ-022 AND/OR/XOR: C=0, V=0.
REQ-023 SHL/SHR (logical, zero fill): C=last bit shifted out, C=0 when shamt=0; shamt>=WIDTH gives result 0, C=0; V=0.
REQ-024 MUL: result=low WIDTH bits of unsigned A*B; C=1 iff high WIDTH bits nonzero; V=0.
REQ-025 All ops: N=result[WIDTH-1], Z=1 iff result==0.
REQ-026 result and flags SHALL hold between valid pulses; uo is combinational from registers and disp_sel.
REQ-027 acc_mode=1 SHALL use result register value at the start cycle as A (chained accumulation).

Reset
REQ-028 rst=1 SHALL immediately force result=0, flags=0, valid=0, busy=0, state IDLE, multiplier state cleared.
REQ-029 Reset during MUL SHALL abort it with no valid pulse; first start after release is accepted normally.

Structure
REQ-030 Shared package alu_pkg SHALL hold opcode constants, flag bit indices (C=3, V=2, N=1, Z=0) and the FSM state enum.
REQ-031 Serial multiplier SHALL be a sub-module alu_mul_serie (start, done, WIDTH-parameterised); all else in alu_registrada.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F,b=0x01 -> next edge result=0x80, flags=0110 (V,N), valid one cycle.
REQ-033 SUB a=0x05,b=0x05 -> result=0x00, flags=1001 (C,Z); a=0x03,b=0x05 -> 0xFE, flags=0010.
REQ-034 MUL a=0x10,b=0x20 -> busy 8 cycles, then result=0x00, flags=1001, valid at edge 9; start during busy ignored.
REQ-035 SHL a=0x81,shamt=1 -> result=0x02, C=1; SHR a=0x81,shamt=0 -> 0x81, C=0; shamt=9 -> 0x00.
REQ-036 acc_mode: ADD a=0x03,b=0x04 then ADD acc_mode=1,b=0x05 -> result 0x07 then 0x0C; disp_sel=1 shows 0x00.
REQ-037 rst asserted mid-MUL -> outputs 0 same cycle, no valid; new ADD after release completes in 1 cycle.
